bcd_serial_subtractor: RTL and testbench
========================================

// Module: bcd_serial_subtractor
// PURPOSE
// - Digit-serial decimal subtractor for DIGITS-digit packed-BCD mantissas.
// - Computes the magnitude |M1 - M2| and a sign bit. Takes one digit per clock, starting with the least significant digit.
// - Counterpart to the mantissa BCD adder: the decimal FP datapath uses it for effective subtraction and for mantissa compare.
// - Interface is start/busy/done. Results are registered and held until the next start.
// PARAMETERS
// - DIGITS  default 7  : number of BCD digits per operand. Operand width W = 4*DIGITS = 28.
// PORTS
// - clk      in   1  : clock. Single clock domain.
// - rst      in   1  : synchronous, active-high reset.
// - start    in   1  : request. Accepted only when busy=0.
// - M1       in   W  : minuend, packed BCD. Sampled on the accepting edge.
// - M2       in   W  : subtrahend, packed BCD. Sampled on the accepting edge.
// - Mr       out  W  : |M1-M2| in packed BCD. Valid when done=1, then held.
// - sign     out  1  : 1 when M1 < M2. Valid when done=1, then held.
// - invalid  out  1  : some input digit was greater than 9. Valid when done=1, then held.
// - busy     out  1  : high from the accepting edge through the done cycle, inclusive.
// - done     out  1  : registered single-cycle completion pulse.
// BEHAVIOUR
// - Reset values: Mr=0, sign=0, invalid=0, busy=0, done=0. FSM goes to IDLE. Digit index=0, borrow=0.
// - FSM states:
//   - IDLE: on start, latch M1/M2, clear index and borrow, set busy.
//     - If any digit of M1 or M2 is greater than 9, go to DONE with Mr=0, sign=0, invalid=1.
//     - Otherwise go to SUB.
//   - SUB: each cycle process digit i. Form the 5-bit value t = a_i - b_i - borrow.
//     - If t[4]=1: digit = t[3:0] + 10 (mod 16), borrow = 1.
//     - Otherwise: digit = t[3:0], borrow = 0.
//     - Write the digit to the result register at slice [4i +: 4].
//     - After digit DIGITS-1: if final borrow=0, go to DONE with sign=0. If final borrow=1, go to NEG.
//   - NEG: ten's-complement the result in place, one digit per cycle, LSD first.
//     - Compute r_i' = 0 - r_i - borrow2, with the same +10 rule. borrow2 starts at 0.
//     - Go to DONE after DIGITS cycles with sign=1.
//   - DONE: done=1 and busy=1 for one cycle. Next state is IDLE.
// - Latency, counted from the edge that accepts start to the first cycle with done=1:
//   - DIGITS clocks for a non-negative result.
//   - 2*DIGITS clocks for a negative result.
//   - 1 clock for an invalid input.
// - Mr, sign and invalid update only on the done edge and hold until the next done.
// - The internal working register is separate from Mr.
// - Boundary rules:
//   - Equal operands give Mr=0 and sign=0. There is never a negative zero.
//   - A start while busy=1 (including the done cycle) is ignored, with no effect on the operation in flight.
//   - rst mid-operation aborts: no done pulse, all outputs return to reset values.
//   - rst and start in the same cycle: rst wins.
//   - The borrow chain can ripple across all digits, e.g. 1000000-0000001.
// - Output digits are always in the range 0..9.
// STRUCTURE
// - Shared header bcd_defs.vh holds:
//   - BCD_DIGIT_W=4, BCD_RADIX=10, BCD_DIGITS_DEFAULT=7.
//   - FSM state encodings ST_IDLE, ST_SUB, ST_NEG, ST_DONE.
// - Sub-module bcd_digit_sub: combinational, inputs (a[3:0], b[3:0], bin), outputs (d[3:0], bout).
//   - One instance serves both SUB and NEG. In NEG, drive a=0 and b=r_i.
// - Top level contains the FSM, the digit index counter (clog2(DIGITS) bits), the operand and working registers, and the output registers.
// TESTING
// 1. M1=0x0000123, M2=0x0000045 -> Mr=0x0000078, sign=0, invalid=0. done exactly 7 clocks after start.
// 2. M1=0x0000045, M2=0x0000123 -> Mr=0x0000078, sign=1. done exactly 14 clocks after start.
// 3. M1=M2=0x9999999 -> Mr=0x0000000, sign=0. Also M1=M2=0 gives the same result.
// 4. M1=0x1000000, M2=0x0000001 -> Mr=0x0999999, sign=0 (full borrow ripple).
//    M1=0, M2=0x9999999 -> Mr=0x9999999, sign=1.
// 5. M1=0x00000A0, any M2 -> invalid=1, Mr=0, sign=0. done 1 clock after start.
//    A following valid op clears invalid.
// 6. start a negative op, then:
//    - pulse start again at clock 3 -> ignored, original result returned.
//    - in a separate run, assert rst at clock 10 -> no done, all outputs 0, and the next start completes normally.

Source files
------------

// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared BCD constants, FSM state encoding and digit helpers for the serial subtractor.
package bcd_serial_subtractor_pkg;

  localparam int BCD_DIGIT_W        = 4;
  localparam int BCD_RADIX          = 10;
  localparam int BCD_DIGITS_DEFAULT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_bad_digit(input logic [BCD_DIGIT_W-1:0] dig);
    return (dig > 4'(BCD_RADIX - 1));
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// One BCD digit of subtraction: d = a - b - bin with decimal wrap, bout on underflow.
module bcd_serial_subtractor_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] t_s;

  // Five-bit difference; bit 4 flags a negative digit that needs +10 correction.
  always_comb begin
    t_s  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    bout = t_s[4];
    if (t_s[4]) begin
      d = t_s[3:0] + 4'(BCD_RADIX);
    end else begin
      d = t_s[3:0];
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor producing |M1-M2| and sign, LSD first.
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   M1,
  input  logic [4*DIGITS-1:0]   M2,
  output logic [4*DIGITS-1:0]   Mr,
  output logic                  sign,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);

  state_e           state_r, state_n_s;
  logic [IDX_W-1:0] idx_r, idx_n_s;
  logic             borrow_r, borrow_n_s;
  logic [W-1:0]     a_r, a_n_s, b_r, b_n_s, work_r, work_n_s;
  logic             inv_r, inv_n_s;
  logic [W-1:0]     mr_r, mr_n_s;
  logic             sign_r, sign_n_s, invalid_r, invalid_n_s;
  logic             busy_r, busy_n_s, done_r, done_n_s;

  logic [W-1:0]     sh_a_s, sh_b_s, sh_w_s, merged_s;
  logic [3:0]       sub_a_s, sub_b_s, sub_d_s;
  logic             sub_bout_s, last_s;

  function automatic logic any_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | is_bad_digit(v[4*i +: 4]);
    end
    return bad;
  endfunction

  // In NEG the same digit cell computes 0 - r_i - borrow, i.e. the ten's complement.
  always_comb begin
    sh_a_s   = a_r >> {idx_r, 2'b00};
    sh_b_s   = b_r >> {idx_r, 2'b00};
    sh_w_s   = work_r >> {idx_r, 2'b00};
    sub_a_s  = (state_r == ST_NEG) ? 4'd0 : sh_a_s[3:0];
    sub_b_s  = (state_r == ST_NEG) ? sh_w_s[3:0] : sh_b_s[3:0];
    merged_s = (work_r & ~(W'(4'hF) << {idx_r, 2'b00})) | (W'(sub_d_s) << {idx_r, 2'b00});
    last_s   = (idx_r == IDX_W'(DIGITS - 1));
  end

  bcd_serial_subtractor_digit_sub u_digit_sub (
    .a    (sub_a_s),
    .b    (sub_b_s),
    .bin  (borrow_r),
    .d    (sub_d_s),
    .bout (sub_bout_s)
  );

  // Next-state and next-register logic for the IDLE/SUB/NEG/DONE sequencer.
  always_comb begin
    state_n_s   = state_r;
    idx_n_s     = idx_r;
    borrow_n_s  = borrow_r;
    a_n_s       = a_r;
    b_n_s       = b_r;
    work_n_s    = work_r;
    inv_n_s     = inv_r;
    mr_n_s      = mr_r;
    sign_n_s    = sign_r;
    invalid_n_s = invalid_r;
    busy_n_s    = busy_r;
    done_n_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_n_s      = M1;
          b_n_s      = M2;
          idx_n_s    = '0;
          borrow_n_s = 1'b0;
          inv_n_s    = any_bad(M1) | any_bad(M2);
          busy_n_s   = 1'b1;
          state_n_s  = ST_SUB;
        end else begin
          busy_n_s   = 1'b0;
        end
      end
      ST_SUB: begin
        if (inv_r) begin
          mr_n_s      = '0;
          sign_n_s    = 1'b0;
          invalid_n_s = 1'b1;
          done_n_s    = 1'b1;
          state_n_s   = ST_DONE;
        end else begin
          work_n_s   = merged_s;
          borrow_n_s = sub_bout_s;
          idx_n_s    = idx_r + IDX_W'(1);
          if (last_s) begin
            idx_n_s = '0;
            if (sub_bout_s) begin
              borrow_n_s = 1'b0;
              state_n_s  = ST_NEG;
            end else begin
              mr_n_s      = merged_s;
              sign_n_s    = 1'b0;
              invalid_n_s = 1'b0;
              done_n_s    = 1'b1;
              state_n_s   = ST_DONE;
            end
          end else begin
            state_n_s = ST_SUB;
          end
        end
      end
      ST_NEG: begin
        work_n_s   = merged_s;
        borrow_n_s = sub_bout_s;
        idx_n_s    = idx_r + IDX_W'(1);
        if (last_s) begin
          idx_n_s     = '0;
          mr_n_s      = merged_s;
          sign_n_s    = 1'b1;
          invalid_n_s = 1'b0;
          done_n_s    = 1'b1;
          state_n_s   = ST_DONE;
        end else begin
          state_n_s = ST_NEG;
        end
      end
      ST_DONE: begin
        busy_n_s  = 1'b0;
        state_n_s = ST_IDLE;
      end
      default: begin
        busy_n_s  = 1'b0;
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      borrow_r  <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      work_r    <= '0;
      inv_r     <= 1'b0;
      mr_r      <= '0;
      sign_r    <= 1'b0;
      invalid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      idx_r     <= idx_n_s;
      borrow_r  <= borrow_n_s;
      a_r       <= a_n_s;
      b_r       <= b_n_s;
      work_r    <= work_n_s;
      inv_r     <= inv_n_s;
      mr_r      <= mr_n_s;
      sign_r    <= sign_n_s;
      invalid_r <= invalid_n_s;
      busy_r    <= busy_n_s;
      done_r    <= done_n_s;
    end
  end

  assign Mr      = mr_r;
  assign sign    = sign_r;
  assign invalid = invalid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed, table-driven bench for bcd_serial_subtractor with abort/ignore corner sequences.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [27:0] M1 = 28'h0;
  logic [27:0] M2 = 28'h0;
  logic [27:0] Mr;
  logic        sign, invalid, busy, done;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [27:0] m1;
    logic [27:0] m2;
    logic [27:0] mr;
    logic        sgn;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  bcd_serial_subtractor dut (
    .clk(clk), .rst(rst), .start(start), .M1(M1), .M2(M2),
    .Mr(Mr), .sign(sign), .invalid(invalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, optionally injecting spurious starts while busy and in the done cycle.
  task automatic run_op(input vec_t v, input bit inject);
    int  lat;
    bit  got;
    bit  busy_ok;
    lat = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    M1 = v.m1;
    M2 = v.m2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (inject && lat == 3) begin
        start = 1'b1;
        M1 = 28'h0000009;
        M2 = 28'h0000001;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(lat), 32'(v.lat));
      check("Mr", 32'(Mr), 32'(v.mr));
      check("sign", 32'(sign), 32'(v.sgn));
      check("invalid", 32'(invalid), 32'(v.inv));
      check("busy_held", 32'(busy_ok), 32'd1);
      if (inject) start = 1'b1;
      tick();
      start = 1'b0;
      check("done_pulse", 32'(done), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
      check("Mr_hold", 32'(Mr), 32'(v.mr));
    end
  endtask

  initial begin
    vecs[0]  = '{28'h0000123, 28'h0000045, 28'h0000078, 1'b0, 1'b0, 7};
    vecs[1]  = '{28'h0000045, 28'h0000123, 28'h0000078, 1'b1, 1'b0, 14};
    vecs[2]  = '{28'h9999999, 28'h9999999, 28'h0000000, 1'b0, 1'b0, 7};
    vecs[3]  = '{28'h0000000, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 7};
    vecs[4]  = '{28'h1000000, 28'h0000001, 28'h0999999, 1'b0, 1'b0, 7};
    vecs[5]  = '{28'h0000000, 28'h9999999, 28'h9999999, 1'b1, 1'b0, 14};
    vecs[6]  = '{28'h00000A0, 28'h0000005, 28'h0000000, 1'b0, 1'b1, 1};
    vecs[7]  = '{28'h0000005, 28'h0000003, 28'h0000002, 1'b0, 1'b0, 7};
    vecs[8]  = '{28'h5000000, 28'h4999999, 28'h0000001, 1'b0, 1'b0, 7};
    vecs[9]  = '{28'h1234567, 28'h7654321, 28'h6419754, 1'b1, 1'b0, 14};
    vecs[10] = '{28'h0000001, 28'hF000000, 28'h0000000, 1'b0, 1'b1, 1};
    vecs[11] = '{28'h0000300, 28'h0000299, 28'h0000001, 1'b0, 1'b0, 7};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_Mr", 32'(Mr), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], 1'b0);
    end

    // Spurious starts at clock 3 and during the done cycle must be ignored.
    run_op(vecs[1], 1'b1);

    // Reset at clock 10 of a negative op aborts with no done pulse.
    begin
      bit saw_done;
      saw_done = 1'b0;
      M1 = 28'h0000045;
      M2 = 28'h0000123;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
        tick();
        if (done) saw_done = 1'b1;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_Mr", 32'(Mr), 32'd0);
      check("abort_sign", 32'(sign), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      for (int c = 0; c < 20; c++) begin
        tick();
        if (done) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
    end
    run_op(vecs[0], 1'b0);

    // rst and start together: rst wins.
    M1 = 28'h0000045;
    M2 = 28'h0000123;
    start = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_Mr", 32'(Mr), 32'd0);
    tick();
    check("rst_start_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
